// File: rtl/spi_diagnostics_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_diagnostics_if
// Description : Bundles the SPI pins, the diagnostic side of the SRAM bus
//               and the VRAM read port used by spi_diagnostics.
//               master = the diagnostics controller, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_diagnostics_if;
    logic        spi_cs_n;
    logic        spi_clk_in;
    logic        spi_mosi;
    logic        spi_out;
    logic [15:0] ram_address;
    logic [7:0]  ram_dataout;
    logic [7:0]  ram_datain;
    logic        ram_we;
    logic        ram_cs;
    logic [10:0] vram_read_address;
    logic [7:0]  vram_output;
    logic        vram_read_clock;

    modport master (
        input  spi_cs_n, spi_clk_in, spi_mosi, ram_dataout, vram_output,
        output spi_out, ram_address, ram_datain, ram_we, ram_cs,
               vram_read_address, vram_read_clock
    );

    modport slave (
        output spi_cs_n, spi_clk_in, spi_mosi, ram_dataout, vram_output,
        input  spi_out, ram_address, ram_datain, ram_we, ram_cs,
               vram_read_address, vram_read_clock
    );
endinterface
`default_nettype wire

// File: rtl/spi_diagnostics.sv
`default_nettype none
// ============================================================================
// Module      : spi_diagnostics
// Description : SPI-slave (mode 0, MSB first) diagnostics controller. Lets a
//               host halt/resume the CPU, read/write SRAM while halted, stream
//               VRAM and query/override the configuration index.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_diagnostics #(
    parameter int SYNC_STAGES = 3
) (
    input  wire                clk,
    input  wire                reset,
    output logic               halt,
    input  wire  [3:0]         configuration,
    output logic [3:0]         config_byte,
    input  wire  [10:0]        vram_size,
    spi_diagnostics_if.master  bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_HI = 3'd1;
    localparam logic [2:0] ST_ADDR_LO = 3'd2;
    localparam logic [2:0] ST_STREAM  = 3'd3;
    localparam logic [2:0] ST_SETCFG  = 3'd4;
    localparam logic [2:0] ST_IGNORE  = 3'd5;

    localparam logic [1:0] ACC_NONE    = 2'd0;
    localparam logic [1:0] ACC_WAIT    = 2'd1;
    localparam logic [1:0] ACC_CAPTURE = 2'd2;

    localparam logic [7:0] OP_HALT   = 8'h01;
    localparam logic [7:0] OP_RUN    = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h04;
    localparam logic [7:0] OP_GETCFG = 8'h05;
    localparam logic [7:0] OP_SETCFG = 8'h06;
    localparam logic [7:0] OP_VREAD  = 8'h07;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    logic        cs_active;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic [15:0] full_addr;
    logic [15:0] addr_inc;
    logic [10:0] vram_start;
    logic [10:0] vram_inc;
    logic [10:0] vram_next;

    logic [2:0]  state;
    logic [1:0]  acc;
    logic [7:0]  cmd;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [15:0] addr;
    logic [15:0] ram_address;
    logic [7:0]  ram_datain;
    logic        ram_cs;
    logic        ram_we;
    logic [10:0] vram_addr;
    logic        override;
    logic [3:0]  override_val;

    // Bring the asynchronous SPI pins into the clk domain; CS idles deasserted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // Edge detection, received byte assembly and next-address arithmetic
    always_comb begin
        cs_active  = ~cs_sync[SYNC_STAGES-1];
        sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
        sclk_fall  = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
        rx_byte    = {rx_shift, mosi_sync[SYNC_STAGES-1]};
        byte_done  = cs_active & sclk_rise & (bit_cnt == 3'd7);
        full_addr  = {addr[15:8], rx_byte};
        addr_inc   = addr + 16'd1;
        vram_start = (vram_size == 11'd0) ? 11'd0 : full_addr[10:0];
        vram_inc   = vram_addr + 11'd1;
        vram_next  = (vram_size == 11'd0 || vram_inc >= vram_size) ? 11'd0 : vram_inc;
    end

    // Command decoder, SPI shift registers and the SRAM/VRAM access sequencer.
    // A fetch holds ram_cs for two clocks and captures data on the second, so
    // the reply is preloaded well before the host starts the next byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            acc          <= ACC_NONE;
            cmd          <= 8'h00;
            bit_cnt      <= 3'd0;
            rx_shift     <= 7'd0;
            tx_shift     <= 8'h00;
            addr         <= 16'h0000;
            ram_address  <= 16'h0000;
            ram_datain   <= 8'h00;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            vram_addr    <= 11'd0;
            halt         <= 1'b0;
            override     <= 1'b0;
            override_val <= 4'h0;
        end else if (!cs_active) begin
            // Deselect aborts any byte or command in progress
            state    <= ST_IDLE;
            acc      <= ACC_NONE;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (acc == ACC_NONE) begin
                ram_cs <= 1'b0;
            end

            if (sclk_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                // The falling edge after bit 8 must not disturb the preloaded byte
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            case (acc)
                ACC_WAIT:    acc <= ACC_CAPTURE;
                ACC_CAPTURE: begin
                    acc      <= ACC_NONE;
                    ram_cs   <= 1'b0;
                    tx_shift <= (cmd == OP_VREAD) ? bus.vram_output : bus.ram_dataout;
                end
                default: ;
            endcase

            if (byte_done) begin
                tx_shift <= 8'h00;
                case (state)
                    ST_IDLE: begin
                        cmd   <= rx_byte;
                        state <= ST_IGNORE;
                        case (rx_byte)
                            OP_HALT:                     halt  <= 1'b1;
                            OP_RUN:                      halt  <= 1'b0;
                            OP_READ, OP_WRITE, OP_VREAD: state <= ST_ADDR_HI;
                            OP_GETCFG:                   tx_shift <= {4'h0, configuration};
                            OP_SETCFG:                   state <= ST_SETCFG;
                            default: ;
                        endcase
                    end
                    ST_ADDR_HI: begin
                        addr[15:8] <= rx_byte;
                        state      <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        addr  <= full_addr;
                        state <= ST_STREAM;
                        if (cmd == OP_READ) begin
                            ram_address <= full_addr;
                            if (halt) begin
                                ram_cs <= 1'b1;
                                acc    <= ACC_WAIT;
                            end
                        end else if (cmd == OP_VREAD) begin
                            vram_addr <= vram_start;
                            acc       <= ACC_WAIT;
                        end
                    end
                    ST_STREAM: begin
                        if (cmd == OP_READ) begin
                            addr        <= addr_inc;
                            ram_address <= addr_inc;
                            if (halt) begin
                                ram_cs <= 1'b1;
                                acc    <= ACC_WAIT;
                            end
                        end else if (cmd == OP_WRITE) begin
                            ram_address <= addr;
                            ram_datain  <= rx_byte;
                            addr        <= addr_inc;
                            if (halt) begin
                                ram_cs <= 1'b1;
                                ram_we <= 1'b1;
                            end
                        end else begin
                            vram_addr <= vram_next;
                            acc       <= ACC_WAIT;
                        end
                    end
                    ST_SETCFG: begin
                        override_val <= rx_byte[3:0];
                        override     <= 1'b1;
                        state        <= ST_IGNORE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.spi_out           = cs_active & tx_shift[7];
    assign bus.ram_address       = ram_address;
    assign bus.ram_datain        = ram_datain;
    assign bus.ram_cs            = ram_cs;
    assign bus.ram_we            = ram_we;
    assign bus.vram_read_address = vram_addr;
    assign bus.vram_read_clock   = clk;
    assign config_byte           = override ? override_val : configuration;

endmodule
`default_nettype wire

// File: tb/tb_spi_diagnostics.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_diagnostics
// Description : Scoreboard bench for spi_diagnostics: an SPI host drives
//               directed commands, SRAM/VRAM models answer the bus, and
//               monitors compare MISO bytes, write strobes and read addresses
//               against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_diagnostics;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic [3:0]  configuration;
    logic [3:0]  config_byte;
    logic [10:0] vram_size;

    spi_diagnostics_if bus();

    int checks    = 0;
    int errors    = 0;
    int gated_cnt = 0;

    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } miso_exp_t;

    miso_exp_t   miso_q[$];
    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  sram [0:65535];

    always #5 clk = ~clk;

    spi_diagnostics #(.SYNC_STAGES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .configuration (configuration),
        .config_byte   (config_byte),
        .vram_size     (vram_size),
        .bus           (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM model: registered read data one clock after chip select
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we)
            sram[bus.ram_address] <= bus.ram_datain;
        else if (bus.ram_cs)
            bus.ram_dataout <= sram[bus.ram_address];
    end

    // VRAM model: content is address + 0x11, one clock latency
    always @(posedge clk) bus.vram_output <= 8'(bus.vram_read_address + 11'h011);

    // SRAM bus monitor: write strobes, read-start addresses, halt gating
    logic prev_we = 1'b0;
    logic prev_cs = 1'b0;
    always @(negedge clk) begin
        if (bus.ram_cs && !halt) gated_cnt++;
        if (bus.ram_cs && bus.ram_we) begin
            check("write strobe width", 32'(prev_we), 32'd0);
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected write: addr 0x%0h data 0x%0h", bus.ram_address, bus.ram_datain);
            end else begin
                check("write addr/data", 32'({bus.ram_address, bus.ram_datain}), 32'(wr_q.pop_front()));
            end
        end else if (bus.ram_cs && !prev_cs) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected read: addr 0x%0h", bus.ram_address);
            end else begin
                check("read addr", 32'(bus.ram_address), 32'(rd_q.pop_front()));
            end
        end
        prev_we = bus.ram_we;
        prev_cs = bus.ram_cs;
    end

    // MISO monitor: assemble bytes on host rising edges and score them
    int        mbits    = 0;
    int        byte_idx = 0;
    logic [7:0] mshift  = 8'h00;
    miso_exp_t mexp;
    always @(posedge bus.spi_clk_in or posedge bus.spi_cs_n) begin
        if (bus.spi_cs_n) begin
            mbits = 0;
        end else begin
            mshift = {mshift[6:0], bus.spi_out};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (miso_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected miso byte: got 0x%0h", mshift);
                end else begin
                    mexp = miso_q.pop_front();
                    if (mexp.chk)
                        check($sformatf("miso byte %0d", byte_idx), 32'(mshift), 32'(mexp.val));
                end
                byte_idx++;
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk); bus.spi_mosi = b[i];
            repeat (4) @(negedge clk); bus.spi_clk_in = 1'b1;
            repeat (4) @(negedge clk); bus.spi_clk_in = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic chk, input logic [7:0] exp);
        miso_q.push_back({chk, exp});
        spi_bits(b, 8);
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk); bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        @(negedge clk); bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; configuration = 4'h5; vram_size = 11'd128;
        bus.spi_cs_n = 1'b1; bus.spi_clk_in = 1'b0; bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("reset halt",        32'(halt), 32'd0);
        check("reset ram_cs",      32'(bus.ram_cs), 32'd0);
        check("reset ram_we",      32'(bus.ram_we), 32'd0);
        check("reset ram_address", 32'(bus.ram_address), 32'd0);
        check("reset ram_datain",  32'(bus.ram_datain), 32'd0);
        check("reset vram_addr",   32'(bus.vram_read_address), 32'd0);
        check("reset spi_out",     32'(bus.spi_out), 32'd0);
        check("reset config_byte", 32'(config_byte), 32'h5);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // GETCFG
        cs_begin(); xfer(8'h05, 1, 8'h00); xfer(8'h00, 1, 8'h05); cs_end();

        // HALT / RUN / HALT
        cs_begin(); xfer(8'h01, 1, 8'h00); cs_end();
        check("halt after HALT", 32'(halt), 32'd1);
        cs_begin(); xfer(8'h02, 1, 8'h00); cs_end();
        check("halt after RUN", 32'(halt), 32'd0);
        cs_begin(); xfer(8'h01, 1, 8'h00); cs_end();
        check("halt after 2nd HALT", 32'(halt), 32'd1);

        // WRITE 0x1234: AA, 55
        wr_q.push_back({16'h1234, 8'hAA}); wr_q.push_back({16'h1235, 8'h55});
        cs_begin();
        xfer(8'h04, 1, 8'h00); xfer(8'h12, 1, 8'h00); xfer(8'h34, 1, 8'h00);
        xfer(8'hAA, 1, 8'h00); xfer(8'h55, 1, 8'h00);
        cs_end();

        // READ 0x1234 x2 (prefetch of 0x1236 follows the last byte)
        rd_q.push_back(16'h1234); rd_q.push_back(16'h1235); rd_q.push_back(16'h1236);
        cs_begin();
        xfer(8'h03, 1, 8'h00); xfer(8'h12, 1, 8'h00); xfer(8'h34, 1, 8'h00);
        xfer(8'h00, 1, 8'hAA); xfer(8'h00, 1, 8'h55);
        cs_end();

        // Write and read across the 16-bit wrap
        wr_q.push_back({16'hFFFF, 8'h77}); wr_q.push_back({16'h0000, 8'h88});
        cs_begin();
        xfer(8'h04, 0, 8'h00); xfer(8'hFF, 0, 8'h00); xfer(8'hFF, 0, 8'h00);
        xfer(8'h77, 0, 8'h00); xfer(8'h88, 0, 8'h00);
        cs_end();
        rd_q.push_back(16'hFFFF); rd_q.push_back(16'h0000); rd_q.push_back(16'h0001);
        cs_begin();
        xfer(8'h03, 0, 8'h00); xfer(8'hFF, 0, 8'h00); xfer(8'hFF, 0, 8'h00);
        xfer(8'h00, 1, 8'h77); xfer(8'h00, 1, 8'h88);
        cs_end();

        // Running CPU: reads return 0, writes discarded, no SRAM strobes
        cs_begin(); xfer(8'h02, 0, 8'h00); cs_end();
        check("halt after RUN 2", 32'(halt), 32'd0);
        cs_begin();
        xfer(8'h03, 0, 8'h00); xfer(8'h12, 0, 8'h00); xfer(8'h34, 0, 8'h00);
        xfer(8'h00, 1, 8'h00); xfer(8'h00, 1, 8'h00);
        cs_end();
        cs_begin();
        xfer(8'h04, 0, 8'h00); xfer(8'h12, 0, 8'h00); xfer(8'h34, 0, 8'h00); xfer(8'hEE, 0, 8'h00);
        cs_end();
        cs_begin(); xfer(8'h01, 0, 8'h00); cs_end();
        rd_q.push_back(16'h1234); rd_q.push_back(16'h1235);
        cs_begin();
        xfer(8'h03, 0, 8'h00); xfer(8'h12, 0, 8'h00); xfer(8'h34, 0, 8'h00);
        xfer(8'h00, 1, 8'hAA);
        cs_end();

        // VREAD from 0x07E with vram_size=128: 0x7E, 0x7F, 0x000, 0x001
        cs_begin();
        xfer(8'h07, 0, 8'h00); xfer(8'h00, 0, 8'h00); xfer(8'h7E, 0, 8'h00);
        xfer(8'h00, 1, 8'h8F); xfer(8'h00, 1, 8'h90); xfer(8'h00, 1, 8'h11); xfer(8'h00, 1, 8'h12);
        cs_end();
        check("vram addr after stream", 32'(bus.vram_read_address), 32'h002);

        // VREAD with vram_size=0 stays at address 0
        vram_size = 11'd0;
        cs_begin();
        xfer(8'h07, 0, 8'h00); xfer(8'h00, 0, 8'h00); xfer(8'h05, 0, 8'h00);
        xfer(8'h00, 1, 8'h11); xfer(8'h00, 1, 8'h11);
        cs_end();
        check("vram addr size 0", 32'(bus.vram_read_address), 32'h000);
        vram_size = 11'd128;

        // SETCFG override
        cs_begin(); xfer(8'h06, 0, 8'h00); xfer(8'h0B, 0, 8'h00); cs_end();
        check("config_byte override", 32'(config_byte), 32'hB);
        configuration = 4'h3;
        repeat (2) @(negedge clk);
        check("config_byte override held", 32'(config_byte), 32'hB);
        cs_begin(); xfer(8'h05, 0, 8'h00); xfer(8'h00, 1, 8'h03); cs_end();

        // CS raised mid address byte: no strobe, next command parses normally
        cs_begin(); xfer(8'h04, 0, 8'h00); xfer(8'h12, 0, 8'h00); spi_bits(8'h34, 4); cs_end();
        cs_begin(); xfer(8'h05, 0, 8'h00); xfer(8'h00, 1, 8'h03); cs_end();
        wr_q.push_back({16'h0042, 8'h5A});
        cs_begin();
        xfer(8'h04, 0, 8'h00); xfer(8'h00, 0, 8'h00); xfer(8'h42, 0, 8'h00); xfer(8'h5A, 0, 8'h00);
        cs_end();
        check("halt kept across CS", 32'(halt), 32'd1);

        repeat (20) @(negedge clk);
        check("miso queue drained",  32'(miso_q.size()), 32'd0);
        check("write queue drained", 32'(wr_q.size()), 32'd0);
        check("read queue drained",  32'(rd_q.size()), 32'd0);
        check("ram_cs while running", 32'(gated_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
